// File: rtl/noc_pkg.sv
// Shared router definitions: flit type codes, flit field positions,
// output-port indices and the input-controller state encoding.
package noc_pkg;

  // Flit type codes carried in the two MSBs of every flit
  localparam logic [1:0] FT_HT   = 2'b00;  // single-flit packet (head+tail)
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  // Field positions within a 12-bit flit
  localparam int TYPE_HI = 11;
  localparam int TYPE_LO = 10;
  localparam int DX_HI   = 5;
  localparam int DX_LO   = 3;
  localparam int DY_HI   = 2;
  localparam int DY_LO   = 0;

  // Output-port indices of the one-hot request vector
  localparam int NUM_PORTS = 5;
  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_S = 3;
  localparam int P_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    HEAD_WAIT,
    REQ,
    SEND,
    BODY_STALL,
    BODY_WAIT
  } state_t;

  // True for the two types that open a packet
  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == FT_HT) || (ftype == FT_HEAD);
  endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-ordered XY route decode: resolve X first, then Y, else local.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic [COORD_W-1:0]   dest_x,
  input  logic [COORD_W-1:0]   dest_y,
  input  logic [COORD_W-1:0]   cur_x,
  input  logic [COORD_W-1:0]   cur_y,
  output logic [NUM_PORTS-1:0] port
);

  // One-hot port select from unsigned coordinate compares
  always_comb begin
    port = '0;
    if (dest_x > cur_x)      port[P_E] = 1'b1;
    else if (dest_x < cur_x) port[P_W] = 1'b1;
    else if (dest_y > cur_y) port[P_N] = 1'b1;
    else if (dest_y < cur_y) port[P_S] = 1'b1;
    else                     port[P_L] = 1'b1;
  end

endmodule

// File: rtl/input_route_ctrl.sv
// Input-port controller: pops flits from the input FIFO, routes the head
// flit XY-style, requests the output port and streams the packet to the
// crossbar, holding the request until the last flit is accepted.
module input_route_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int COORD_W    = 3,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]  req,
  input  logic [NUM_PORTS-1:0]  grant,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);

  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   flit_q;
  logic [NUM_PORTS-1:0]    route_q;
  logic                    out_valid_q;
  logic                    err_q;
  logic                    last_q;     // flit in flit_q closes the packet

  logic [1:0]              in_type;
  logic [NUM_PORTS-1:0]    route_d;

  assign in_type = fifo_data[TYPE_HI:TYPE_LO];

  xy_route_calc #(
    .COORD_W (COORD_W)
  ) u_xy_route_calc (
    .dest_x (COORD_W'(fifo_data[DX_HI:DX_LO])),
    .dest_y (COORD_W'(fifo_data[DY_HI:DY_LO])),
    .cur_x  (CX),
    .cur_y  (CY),
    .port   (route_d)
  );

  // Pop strobe is decoded from the current state so a pop lands in the same
  // cycle the FIFO is seen non-empty; gating on rst keeps it low in reset.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (rst && !fifo_empty) begin
      case (state_q)
        IDLE:       fifo_rd_en = 1'b1;
        SEND:       fifo_rd_en = out_ready && !last_q;
        BODY_STALL: fifo_rd_en = 1'b1;
        default:    fifo_rd_en = 1'b0;
      endcase
    end
  end

  // Packet FSM with registered request, valid, data and error outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      flit_q      <= '0;
      route_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= HEAD_WAIT;
        end
        HEAD_WAIT: begin
          flit_q <= fifo_data;
          if (is_head(in_type)) begin
            route_q <= route_d;
            last_q  <= (in_type == FT_HT);
            state_q <= REQ;
          end else begin
            err_q   <= 1'b1;   // stray body/tail: drop it
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (|(grant & route_q)) begin
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_q) begin
              route_q <= '0;
              state_q <= IDLE;
            end else if (!fifo_empty) begin
              state_q <= BODY_WAIT;
            end else begin
              state_q <= BODY_STALL;
            end
          end
        end
        BODY_STALL: begin
          if (!fifo_empty) state_q <= BODY_WAIT;
        end
        BODY_WAIT: begin
          // A head arriving mid-packet is flagged, forwarded and ends the packet
          flit_q      <= fifo_data;
          last_q      <= (in_type != FT_BODY);
          err_q       <= is_head(in_type);
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req       = route_q;
  assign out_flit  = flit_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_input_route_ctrl.sv
// Bench for input_route_ctrl at router (2,2) with a queue-based FIFO model,
// a grant model and a packet-level reference for routes and flit order.
module tb_input_route_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [11:0] fifo_data;
  logic [4:0]  req;
  logic [4:0]  grant;
  logic [11:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  always #5 clk = ~clk;

  input_route_ctrl #(
    .DATA_WIDTH (12),
    .COORD_W    (3),
    .CUR_X      (2),
    .CUR_Y      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .req        (req),
    .grant      (grant),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err)
  );

  typedef struct packed {
    logic       rd;
    logic [4:0] rq;
    logic       ov;
    logic       er;
    logic       hs;
  } cyc_t;

  cyc_t        hist[$];
  logic [11:0] mem[$];
  logic [11:0] arr[$];
  logic [11:0] rx[$];
  logic [4:0]  req_runs[$];
  logic [4:0]  prev_req;
  logic [11:0] prev_flit;
  bit          prev_stall;
  bit          pop_pend;
  bit          gnt_en;
  bit          rand_gnt;
  int          rdy_pct;
  int          checks;
  int          errors;
  int          viol;
  int          err_cnt;
  int          req_change;
  int          stab_viol;

  // Reference XY route for router (2,2), straight from the routing rules
  function automatic logic [4:0] ref_route(input int dx, input int dy);
    if (dx > 2) return 5'b00100;
    if (dx < 2) return 5'b10000;
    if (dy > 2) return 5'b00010;
    if (dy < 2) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic logic [11:0] mk(input logic [1:0] t, input int dx, input int dy);
    logic [3:0] pl;
    pl = 4'($urandom_range(15));
    return {t, pl, 3'(dx), 3'(dy)};
  endfunction

  // One clock cycle: FIFO/grant/ready updates at negedge, observe 1ns later
  task automatic step();
    cyc_t c;
    @(negedge clk);
    if (pop_pend) begin
      if (mem.size() > 0) fifo_data = mem.pop_front();
      pop_pend = 1'b0;
    end
    while (arr.size() > 0) mem.push_back(arr.pop_front());
    fifo_empty = (mem.size() == 0);
    out_ready  = ($urandom_range(99) < rdy_pct);
    if (rand_gnt) grant = ($urandom_range(1) == 1) ? req : 5'b0;
    else          grant = gnt_en ? req : 5'b0;
    #1;
    c.rd = fifo_rd_en;
    c.rq = req;
    c.ov = out_valid;
    c.er = err;
    c.hs = out_valid && out_ready;
    if (fifo_rd_en) begin
      if (fifo_empty) viol++;
      pop_pend = 1'b1;
    end
    if (c.hs) rx.push_back(out_flit);
    if (err) err_cnt++;
    if (prev_stall && out_valid && (out_flit !== prev_flit)) stab_viol++;
    prev_stall = out_valid && !out_ready;
    prev_flit  = out_flit;
    if (req != 5'b0 && prev_req == 5'b0) req_runs.push_back(req);
    if (req != 5'b0 && prev_req != 5'b0 && req != prev_req) req_change++;
    prev_req = req;
    hist.push_back(c);
  endtask

  task automatic clr();
    hist.delete();
    rx.delete();
    req_runs.delete();
    viol       = 0;
    err_cnt    = 0;
    req_change = 0;
    stab_viol  = 0;
  endtask

  task automatic run_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rx.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (rx.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d flits, required %0d", name, rx.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    arr.push_back(mk(2'b01, 4, 1));
    step();
    step();
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b, required 0", fifo_rd_en); end
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL rst_req: got %b, required 00000", req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", err); end
    checks++; if (out_flit !== 12'h0) begin errors++; $display("FAIL rst_out_flit: got %h, required 000", out_flit); end
    mem.delete();
    fifo_empty = 1'b1;
    pop_pend   = 1'b0;
    rst        = 1'b1;
    step();
  endtask

  task automatic test_basic_packet();
    logic [11:0] exp[3];
    int c0, cr, cv;
    int hs[$];
    clr();
    gnt_en = 1'b1; rdy_pct = 100;
    exp[0] = mk(2'b01, 4, 1);
    exp[1] = mk(2'b10, 7, 7);
    exp[2] = mk(2'b11, 0, 5);
    for (int i = 0; i < 3; i++) arr.push_back(exp[i]);
    run_rx(3, 50, "basic");
    step();
    step();
    c0 = -1; cr = -1; cv = -1;
    foreach (hist[i]) begin
      if (c0 < 0 && hist[i].rd) c0 = i;
      if (cr < 0 && hist[i].rq != 5'b0) cr = i;
      if (cv < 0 && hist[i].ov) cv = i;
      if (hist[i].hs) hs.push_back(i);
    end
    checks++; if (cr !== c0 + 2) begin errors++; $display("FAIL basic_req_latency: got cycle %0d, required %0d", cr, c0 + 2); end
    checks++; if (cv !== c0 + 3) begin errors++; $display("FAIL basic_valid_latency: got cycle %0d, required %0d", cv, c0 + 3); end
    checks++; if (req_runs.size() != 1 || req_runs[0] !== 5'b00100) begin errors++; $display("FAIL basic_req: got %0d runs first %b, required 1 run 00100", req_runs.size(), (req_runs.size() > 0) ? req_runs[0] : 5'b0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx.size() <= i || rx[i] !== exp[i]) begin errors++; $display("FAIL basic_flit%0d: got %h, required %h", i, (rx.size() > i) ? rx[i] : 12'hx, exp[i]); end
    end
    if (hs.size() == 3) begin
      checks++; if (hs[1] - hs[0] != 2 || hs[2] - hs[1] != 2) begin errors++; $display("FAIL basic_throughput: got handshakes at %0d,%0d,%0d, required 2 apart", hs[0], hs[1], hs[2]); end
      checks++; if (hist[hs[2] + 1].rq !== 5'b0) begin errors++; $display("FAIL basic_req_drop: got %b after tail, required 00000", hist[hs[2] + 1].rq); end
    end else begin
      checks++; errors++; $display("FAIL basic_handshakes: got %0d, required 3", hs.size());
    end
  endtask

  task automatic test_single_flit();
    logic [11:0] f;
    clr();
    f = mk(2'b00, 2, 2);
    arr.push_back(f);
    run_rx(1, 20, "single");
    step();
    step();
    step();
    checks++; if (req_runs.size() != 1 || req_runs[0] !== 5'b00001) begin errors++; $display("FAIL single_req: got %0d runs first %b, required 1 run 00001", req_runs.size(), (req_runs.size() > 0) ? req_runs[0] : 5'b0); end
    checks++; if (rx.size() != 1 || rx[0] !== f) begin errors++; $display("FAIL single_flit: got %0d flits first %h, required 1 flit %h", rx.size(), (rx.size() > 0) ? rx[0] : 12'hx, f); end
    checks++; if (req !== 5'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got req %b valid %b, required 00000 0", req, out_valid); end
  endtask

  task automatic test_grant_wait();
    logic [11:0] f;
    int k;
    clr();
    gnt_en = 1'b0;
    f = mk(2'b00, 0, 2);
    arr.push_back(f);
    k = 0;
    while (req == 5'b0 && k < 10) begin step(); k++; end
    checks++; if (req !== 5'b10000) begin errors++; $display("FAIL gw_req: got %b, required 10000", req); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || req !== 5'b10000) begin errors++; $display("FAIL gw_hold%0d: got valid %b req %b, required 0 10000", i, out_valid, req); end
    end
    gnt_en = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gw_grant_cycle: got valid %b, required 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gw_valid_rise: got valid %b, required 1", out_valid); end
    run_rx(1, 10, "gw");
    checks++; if (rx.size() != 1 || rx[0] !== f) begin errors++; $display("FAIL gw_flit: got %h, required %h", (rx.size() > 0) ? rx[0] : 12'hx, f); end
    step();
  endtask

  task automatic test_body_stall();
    logic [11:0] exp[3];
    clr();
    exp[0] = mk(2'b01, 2, 5);
    exp[1] = mk(2'b10, 1, 1);
    exp[2] = mk(2'b11, 6, 0);
    arr.push_back(exp[0]);
    run_rx(1, 20, "stall_head");
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d: got %b, required 0", i, out_valid); end
    end
    arr.push_back(exp[1]);
    arr.push_back(exp[2]);
    run_rx(3, 30, "stall_body");
    step();
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (rx.size() <= i || rx[i] !== exp[i]) begin errors++; $display("FAIL stall_flit%0d: got %h, required %h", i, (rx.size() > i) ? rx[i] : 12'hx, exp[i]); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL stall_rd_empty: got %0d pops while empty, required 0", viol); end
    checks++; if (req_runs.size() != 1 || req_runs[0] !== 5'b00010 || req_change != 0) begin errors++; $display("FAIL stall_req: got %0d runs first %b changes %0d, required 1 run 00010", req_runs.size(), (req_runs.size() > 0) ? req_runs[0] : 5'b0, req_change); end
  endtask

  task automatic test_bad_head();
    logic [11:0] a, b, c;
    clr();
    arr.push_back(mk(2'b10, 5, 5));
    for (int i = 0; i < 6; i++) step();
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL bad_err_pulse: got %0d err cycles, required 1", err_cnt); end
    checks++; if (req_runs.size() != 0) begin errors++; $display("FAIL bad_no_req: got %0d requests, required 0", req_runs.size()); end
    checks++; if (rx.size() != 0) begin errors++; $display("FAIL bad_dropped: got %0d flits out, required 0", rx.size()); end
    a = mk(2'b01, 1, 2);
    b = mk(2'b01, 3, 3);
    arr.push_back(a);
    arr.push_back(b);
    run_rx(2, 30, "midhead");
    step();
    step();
    checks++; if (rx.size() != 2 || rx[0] !== a || rx[1] !== b) begin errors++; $display("FAIL midhead_flits: got %0d flits, required %h %h", rx.size(), a, b); end
    checks++; if (err_cnt != 2) begin errors++; $display("FAIL midhead_err: got %0d err cycles, required 2", err_cnt); end
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL midhead_req_drop: got %b, required 00000", req); end
    c = mk(2'b00, 3, 2);
    arr.push_back(c);
    run_rx(3, 20, "after_bad");
    checks++; if (req_runs.size() != 2 || req_runs[0] !== 5'b10000 || req_runs[1] !== 5'b00100) begin errors++; $display("FAIL after_bad_req: got %0d runs, required 10000 then 00100", req_runs.size()); end
    step();
  endtask

  task automatic test_reset_mid_send();
    logic [11:0] f;
    int k;
    clr();
    rdy_pct = 0;
    arr.push_back(mk(2'b01, 4, 4));
    arr.push_back(mk(2'b10, 0, 0));
    k = 0;
    while (out_valid !== 1'b1 && k < 10) begin step(); k++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rms_reach_send: got valid %b, required 1", out_valid); end
    #1 rst = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0 || req !== 5'b0 || out_valid !== 1'b0 || err !== 1'b0 || out_flit !== 12'h0) begin
      errors++; $display("FAIL rms_outputs: got rd %b req %b valid %b err %b flit %h, required all 0", fifo_rd_en, req, out_valid, err, out_flit);
    end
    mem.delete();
    arr.delete();
    pop_pend = 1'b0;
    step();
    step();
    rst = 1'b1;
    clr();
    rdy_pct = 100;
    f = mk(2'b00, 2, 0);
    arr.push_back(f);
    run_rx(1, 20, "rms_new");
    checks++; if (rx.size() != 1 || rx[0] !== f || req_runs.size() != 1 || req_runs[0] !== 5'b01000) begin errors++; $display("FAIL rms_new_head: got %0d flits %0d runs, required flit %h route 01000", rx.size(), req_runs.size(), f); end
    step();
  endtask

  task automatic test_random();
    logic [11:0] src[$];
    logic [11:0] exp[$];
    logic [4:0]  exp_rt[$];
    int dx, dy, len, k, bad;
    clr();
    rand_gnt = 1'b1;
    rdy_pct  = 60;
    for (int p = 0; p < 25; p++) begin
      dx  = $urandom_range(7);
      dy  = $urandom_range(7);
      len = $urandom_range(1, 4);
      exp_rt.push_back(ref_route(dx, dy));
      if (len == 1) begin
        src.push_back(mk(2'b00, dx, dy));
      end else begin
        src.push_back(mk(2'b01, dx, dy));
        for (int b = 0; b < len - 2; b++) src.push_back(mk(2'b10, $urandom_range(7), $urandom_range(7)));
        src.push_back(mk(2'b11, $urandom_range(7), $urandom_range(7)));
      end
    end
    foreach (src[i]) exp.push_back(src[i]);
    k = 0;
    while (rx.size() < exp.size() && k < 6000) begin
      if (src.size() > 0 && $urandom_range(1) == 1) arr.push_back(src.pop_front());
      step();
      k++;
    end
    step();
    step();
    checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL rand_count: got %0d flits, required %0d", rx.size(), exp.size()); end
    bad = 0;
    foreach (exp[i]) if (i < rx.size() && rx[i] !== exp[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_flits: got %0d flits out of order/corrupt, required 0", bad); end
    checks++; if (req_runs.size() != exp_rt.size()) begin errors++; $display("FAIL rand_req_runs: got %0d, required %0d", req_runs.size(), exp_rt.size()); end
    for (int i = 0; i < exp_rt.size() && i < req_runs.size(); i++) begin
      checks++;
      if (req_runs[i] !== exp_rt[i]) begin errors++; $display("FAIL rand_route%0d: got %b, required %b", i, req_runs[i], exp_rt[i]); end
    end
    checks++; if (viol != 0 || err_cnt != 0 || req_change != 0 || stab_viol != 0) begin
      errors++; $display("FAIL rand_protocol: got empty-pops %0d errs %0d req-changes %0d unstable %0d, required all 0", viol, err_cnt, req_change, stab_viol);
    end
    rand_gnt = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    fifo_empty = 1'b1; fifo_data = '0; grant = '0; out_ready = 1'b0;
    pop_pend = 1'b0; gnt_en = 1'b1; rand_gnt = 1'b0; rdy_pct = 100;
    prev_req = '0; prev_flit = '0; prev_stall = 1'b0;
    rst = 1'b0;
    clr();
    test_reset();
    test_basic_packet();
    test_single_flit();
    test_grant_wait();
    test_body_stall();
    test_bad_head();
    test_reset_mid_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_route_ctrl.md
# input_route_ctrl

Per-input-port controller sitting directly downstream of the input-buffer FIFO in each router port. It pops flits from the FIFO and decodes the head flit's destination with dimension-ordered XY routing. It then requests the selected output port from the switch arbiter and forwards the packet's flits to the crossbar until the tail, holding the output for the whole packet (wormhole switching).

## Interface
- `DATA_WIDTH`, 12: flit width.
- `COORD_W`, 3: width of each X/Y coordinate.
- `CUR_X`, 0: this router's X coordinate.
- `CUR_Y`, 0: this router's Y coordinate.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  input FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO pop strobe; FIFO read chip-select tied high by the parent.
- `fifo_data`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd_en`.
- `req`  out  5  one-hot output-port request to switch arbiter.
- `grant`  in  5  one-hot grant from arbiter.
- `out_flit`  out  DATA_WIDTH  flit to crossbar.
- `out_valid`  out  1  `out_flit` valid.
- `out_ready`  in  1  downstream accepts flit this cycle.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation
- Flit fields: [11:10] type, 00 head+tail (single-flit), 01 head, 10 body, 11 tail. Head dest_x = [5:3], dest_y = [2:0].
- XY route uses unsigned compares:
  - dest_x > CUR_X gives E; dest_x < CUR_X gives W.
  - Otherwise, dest_y > CUR_Y gives N; dest_y < CUR_Y gives S.
  - Otherwise L.
- Port bits: 0 L, 1 N, 2 E, 3 S, 4 W.
- FSM states: IDLE, HEAD_WAIT, REQ, SEND, BODY_STALL, BODY_WAIT.
- IDLE: if !fifo_empty, pulse `fifo_rd_en`, go HEAD_WAIT.
- HEAD_WAIT: latch `fifo_data` into `flit_q`.
  - Type 00 or 01: latch route, go REQ.
  - Body or tail: pulse `err`, drop the flit, go IDLE.
- REQ: drive `req` = route one-hot. When `grant` & `req` is nonzero, go SEND.
- SEND: `out_valid`=1, `out_flit`=`flit_q`. On `out_ready`:
  - Type 00 or 11: go IDLE.
  - Otherwise, if !fifo_empty: pulse `fifo_rd_en`, go BODY_WAIT.
  - Otherwise go BODY_STALL.
- BODY_STALL: `out_valid`=0. When !fifo_empty, pulse `fifo_rd_en`, go BODY_WAIT.
- BODY_WAIT: latch `fifo_data`, go SEND.
  - If the latched flit is head or head+tail, pulse `err`. The flit is forwarded unchanged and treated as the packet's last flit.
- `req` stays asserted from REQ through the last SEND handshake. The arbiter keeps `grant` while `req` is held.
- `fifo_rd_en` is never asserted while `fifo_empty`=1. At most one pop is outstanding at a time.
- `grant` is ignored outside REQ.

## Timing
- Reset (async assert) clears these immediately: `fifo_rd_en`, `req`, `out_valid`, `err` = 0; `out_flit` = 0; state = IDLE; route = 0.
- Reset mid-packet abandons the packet with no flush; flits still in the FIFO are handled by the FIFO's own reset.
- Head latency: FIFO non-empty at edge N gives `fifo_rd_en` high in cycle N.
  - Head latched at N+1.
  - `req` high in cycle N+2.
  - With grant in cycle N+2, `out_valid` is high in cycle N+3.
- Throughput: 1 flit per 2 cycles when the FIFO is non-empty and `out_ready`=1.
- `out_flit` holds stable while `out_valid`=1 and `out_ready`=0.
- `req` drops in the cycle after the tail handshake.
- The next head pop can occur in the IDLE cycle immediately following.
- `err` is high for exactly one cycle.

## Structure
- Shared package `noc_pkg` holds:
  - flit type codes (FT_HT, FT_HEAD, FT_BODY, FT_TAIL);
  - type/dest field bit positions;
  - port index constants P_L..P_W and the port count 5;
  - FSM state enum.
- One sub-module: `xy_route_calc`, combinational. Inputs: dest_x, dest_y, CUR_X/CUR_Y. Output: 5-bit one-hot port.
- `flit_q`, route register and FSM live in `input_route_ctrl`.

## Test plan
- CUR=(2,2), FIFO holds head dest (4,1), body, tail; grant given immediately, `out_ready`=1 → `req`=5'b00100 (E); 3 flits out in order; `req` low the cycle after the tail.
- Single-flit type 00 dest (2,2) → `req`=5'b00001 (L); one flit out; back to IDLE.
- Grant withheld 5 cycles → `out_valid` stays 0 and `req` stays held; `out_valid` rises the cycle after the grant arrives.
- FIFO empties after the head, body arrives 4 cycles later → BODY_STALL with `out_valid`=0 and `fifo_rd_en` never high while empty; body forwarded after refill.
- Body flit (type 10) at head position → `err` pulses 1 cycle, `req` never asserts; the next valid head routes normally.
- Assert `rst` low mid-SEND with `out_ready`=0 → all outputs 0 within the same cycle; after release, the FSM is in IDLE and a new head is accepted.
